ts_rx_qualifier: RTL and testbench

- Per-lane receive-side qualifier between the link partner's 128-bit training-sequence output and the local LTSSM TS input.
- Decodes each 16-symbol TS1/TS2 ordered set and rejects malformed ones.
- Tracks consecutive identical ordered sets and raises TS1/TS2 qualification levels, so the LTSSM can make decisions such as "8 consecutive TS1".
- Provides a gap watchdog and an error counter.

---
 rtl/ts_rx_qualifier_if.sv | 16 +
 rtl/ts_rx_qualifier.sv | 194 +++++++++++++++++++
 tb/tb_ts_rx_qualifier.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_rx_qualifier_if.sv
// ts_rx_qualifier_if
//   Carries one received training-sequence ordered set per valid cycle from
//   the link-partner side into the qualifier.
//   Signals:
//     ts_i      128-bit ordered set, symbol k at bits [8k+7:8k]
//     ts_i_vld  ts_i valid, one ordered set per asserted cycle
//   Modports:
//     master    drives the ordered set (receiver front end / bench)
//     slave     consumes it (ts_rx_qualifier)
interface ts_rx_qualifier_if;
    logic [127:0] ts_i;
    logic         ts_i_vld;

    modport master (output ts_i, output ts_i_vld);
    modport slave  (input  ts_i, input  ts_i_vld);
endinterface

// File: rtl/ts_rx_qualifier.sv
// ts_rx_qualifier
//   Per-lane receive-side TS1/TS2 qualifier. Decodes each 16-symbol ordered
//   set, rejects malformed ones, counts consecutive identical good ordered
//   sets and raises TS1/TS2 qualification levels for the LTSSM. Includes an
//   idle-gap watchdog and a saturating malformed-set counter.
//   All outputs are registered: a beat sampled in cycle N is reflected in N+1.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     clear         LTSSM restart: drops all history except err_cnt
//     rx            slave side of ts_rx_qualifier_if (ts_i, ts_i_vld)
//     ts_type       last good TS: 0 none, 1 TS1, 2 TS2
//     ts_link..ts_ctrl  symbols 1..5 of last good TS
//     ts_upd        one-cycle pulse per accepted good TS
//     consec_cnt    consecutive identical good TS count (saturating)
//     ts1_qual/ts2_qual  qualification levels
//     err_cnt       malformed TS count, saturating at 255
//     gap_timeout   one-cycle pulse when the gap watchdog expires
module ts_rx_qualifier #(
    parameter int CONSEC_TARGET = 8,
    parameter int CNT_W         = 4,
    parameter int GAP_CYCLES    = 1024,
    parameter int GAP_W         = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    ts_rx_qualifier_if.slave   rx,
    output logic [1:0]         ts_type,
    output logic [7:0]         ts_link,
    output logic [7:0]         ts_lane,
    output logic [7:0]         ts_nfts,
    output logic [7:0]         ts_rate,
    output logic [7:0]         ts_ctrl,
    output logic               ts_upd,
    output logic [CNT_W-1:0]   consec_cnt,
    output logic               ts1_qual,
    output logic               ts2_qual,
    output logic [7:0]         err_cnt,
    output logic               gap_timeout
);

    localparam logic [7:0]       SYM_COM = 8'hBC;
    localparam logic [7:0]       SYM_TS1 = 8'h4A;
    localparam logic [7:0]       SYM_TS2 = 8'h45;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(CONSEC_TARGET);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

    // Symbol view of the incoming ordered set
    logic [7:0] sym [16];
    for (genvar k = 0; k < 16; k++) begin : g_sym
        assign sym[k] = rx.ts_i[8*k +: 8];
    end

    logic       tail_ok;
    logic       id_ok;
    logic       good;
    logic       match;
    logic [1:0] new_type;

    // Symbols 7..15 must all repeat the TS identifier in symbol 6
    always_comb begin
        tail_ok = 1'b1;
        for (int k = 7; k < 16; k++) begin
            if (sym[k] != sym[6]) tail_ok = 1'b0;
        end
    end

    assign id_ok    = (sym[6] == SYM_TS1) || (sym[6] == SYM_TS2);
    assign good     = (sym[0] == SYM_COM) && id_ok && tail_ok;
    assign new_type = (sym[6] == SYM_TS1) ? 2'd1 : 2'd2;

    logic [1:0]       type_q,  type_d;
    logic [7:0]       link_q,  link_d;
    logic [7:0]       lane_q,  lane_d;
    logic [7:0]       nfts_q,  nfts_d;
    logic [7:0]       rate_q,  rate_d;
    logic [7:0]       ctrl_q,  ctrl_d;
    logic             upd_q,   upd_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             q1_q,    q1_d;
    logic             q2_q,    q2_d;
    logic [7:0]       err_q,   err_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic             gto_q,   gto_d;

    // A stored type of 0 never equals new_type, so the first good TS after
    // reset/clear always takes the load path.
    assign match = (new_type == type_q) && (sym[1] == link_q) &&
                   (sym[2] == lane_q)   && (sym[3] == nfts_q) &&
                   (sym[4] == rate_q)   && (sym[5] == ctrl_q);

    always_comb begin
        type_d = type_q;
        link_d = link_q;
        lane_d = lane_q;
        nfts_d = nfts_q;
        rate_d = rate_q;
        ctrl_d = ctrl_q;
        upd_d  = 1'b0;
        cnt_d  = cnt_q;
        err_d  = err_q;
        gap_d  = gap_q;
        gto_d  = 1'b0;

        if (clear) begin
            // Beat in the same cycle is discarded; err_cnt survives
            type_d = 2'd0;
            link_d = 8'd0;
            lane_d = 8'd0;
            nfts_d = 8'd0;
            rate_d = 8'd0;
            ctrl_d = 8'd0;
            cnt_d  = '0;
            gap_d  = '0;
        end else if (rx.ts_i_vld) begin
            gap_d = '0;
            if (good) begin
                upd_d = 1'b1;
                if (match) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    type_d = new_type;
                    link_d = sym[1];
                    lane_d = sym[2];
                    nfts_d = sym[3];
                    rate_d = sym[4];
                    ctrl_d = sym[5];
                    cnt_d  = CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
        end else if (gap_q != GAP_MAX) begin
            // Counter parks at GAP_MAX so expiry fires only once per gap
            gap_d = gap_q + GAP_W'(1);
            if (gap_d == GAP_MAX) begin
                cnt_d = '0;
                gto_d = 1'b1;
            end
        end

        // Qualification follows next-state count/type so it lands with them
        q1_d = (cnt_d >= CNT_TGT) && (type_d == 2'd1);
        q2_d = (cnt_d >= CNT_TGT) && (type_d == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q <= 2'd0;
            link_q <= 8'd0;
            lane_q <= 8'd0;
            nfts_q <= 8'd0;
            rate_q <= 8'd0;
            ctrl_q <= 8'd0;
            upd_q  <= 1'b0;
            cnt_q  <= '0;
            q1_q   <= 1'b0;
            q2_q   <= 1'b0;
            err_q  <= 8'd0;
            gap_q  <= '0;
            gto_q  <= 1'b0;
        end else begin
            type_q <= type_d;
            link_q <= link_d;
            lane_q <= lane_d;
            nfts_q <= nfts_d;
            rate_q <= rate_d;
            ctrl_q <= ctrl_d;
            upd_q  <= upd_d;
            cnt_q  <= cnt_d;
            q1_q   <= q1_d;
            q2_q   <= q2_d;
            err_q  <= err_d;
            gap_q  <= gap_d;
            gto_q  <= gto_d;
        end
    end

    assign ts_type     = type_q;
    assign ts_link     = link_q;
    assign ts_lane     = lane_q;
    assign ts_nfts     = nfts_q;
    assign ts_rate     = rate_q;
    assign ts_ctrl     = ctrl_q;
    assign ts_upd      = upd_q;
    assign consec_cnt  = cnt_q;
    assign ts1_qual    = q1_q;
    assign ts2_qual    = q2_q;
    assign err_cnt     = err_q;
    assign gap_timeout = gto_q;

endmodule

// File: tb/tb_ts_rx_qualifier.sv
// tb_ts_rx_qualifier
//   Self-checking bench for ts_rx_qualifier. Every driven cycle pushes the
//   expected next-cycle outputs of a behavioural model onto a scoreboard
//   queue; each scenario task pops and compares after the clock edge and
//   adds scenario-specific checks against fixed values.
module tb_ts_rx_qualifier;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    logic [1:0] ts_type;
    logic [7:0] ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl;
    logic       ts_upd;
    logic [3:0] consec_cnt;
    logic       ts1_qual, ts2_qual;
    logic [7:0] err_cnt;
    logic       gap_timeout;

    ts_rx_qualifier_if rx_if ();

    ts_rx_qualifier #(
        .CONSEC_TARGET (8),
        .CNT_W         (4),
        .GAP_CYCLES    (1024),
        .GAP_W         (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .rx          (rx_if.slave),
        .ts_type     (ts_type),
        .ts_link     (ts_link),
        .ts_lane     (ts_lane),
        .ts_nfts     (ts_nfts),
        .ts_rate     (ts_rate),
        .ts_ctrl     (ts_ctrl),
        .ts_upd      (ts_upd),
        .consec_cnt  (consec_cnt),
        .ts1_qual    (ts1_qual),
        .ts2_qual    (ts2_qual),
        .err_cnt     (err_cnt),
        .gap_timeout (gap_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [1:0] typ;
        logic [7:0] f [1:5];
        logic       upd;
        logic [3:0] cnt;
        logic       q1, q2;
        logic [7:0] err;
        logic       gto;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    logic [1:0] m_typ;
    logic [7:0] m_f [1:5];
    logic [3:0] m_cnt;
    logic [7:0] m_err;
    int         m_gap;

    function automatic logic [127:0] mk_ts(input logic [7:0] id, input logic [7:0] link,
                                           input logic [7:0] lane, input logic [7:0] rate);
        logic [127:0] t;
        t = '0;
        t[7:0]   = 8'hBC;
        t[15:8]  = link;
        t[23:16] = lane;
        t[31:24] = 8'h10;
        t[39:32] = rate;
        t[47:40] = 8'h00;
        for (int k = 6; k < 16; k++) t[8*k +: 8] = id;
        return t;
    endfunction

    function automatic logic [57:0] pack_obs();
        return {ts_type, ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl, ts_upd,
                consec_cnt, ts1_qual, ts2_qual, err_cnt, gap_timeout};
    endfunction

    function automatic logic [57:0] pack_exp(input exp_t x);
        return {x.typ, x.f[1], x.f[2], x.f[3], x.f[4], x.f[5], x.upd,
                x.cnt, x.q1, x.q2, x.err, x.gto};
    endfunction

    // Drive one cycle, advance the model, push its expectation, step the clock
    task automatic drive(input logic r, input logic c, input logic v, input logic [127:0] d);
        exp_t   x;
        logic   good, same;
        logic [1:0] t;
        rst = r; clear = c; rx_if.ts_i_vld = v; rx_if.ts_i = d;
        x.upd = 1'b0;
        x.gto = 1'b0;
        if (r) begin
            m_typ = 0; m_cnt = 0; m_err = 0; m_gap = 0;
            for (int i = 1; i <= 5; i++) m_f[i] = 0;
        end else if (c) begin
            m_typ = 0; m_cnt = 0; m_gap = 0;
            for (int i = 1; i <= 5; i++) m_f[i] = 0;
        end else if (v) begin
            m_gap = 0;
            good = (d[7:0] == 8'hBC) && (d[55:48] == 8'h4A || d[55:48] == 8'h45);
            for (int k = 7; k < 16; k++) if (d[8*k +: 8] != d[55:48]) good = 1'b0;
            if (good) begin
                x.upd = 1'b1;
                t = (d[55:48] == 8'h4A) ? 2'd1 : 2'd2;
                same = (t == m_typ);
                for (int i = 1; i <= 5; i++) if (d[8*i +: 8] != m_f[i]) same = 1'b0;
                if (same) begin
                    if (m_cnt != 4'd15) m_cnt++;
                end else begin
                    m_typ = t;
                    for (int i = 1; i <= 5; i++) m_f[i] = d[8*i +: 8];
                    m_cnt = 1;
                end
            end else begin
                m_cnt = 0;
                if (m_err != 8'd255) m_err++;
            end
        end else if (m_gap < 1024) begin
            m_gap++;
            if (m_gap == 1024) begin
                m_cnt = 0;
                x.gto = 1'b1;
            end
        end
        x.typ = m_typ;
        for (int i = 1; i <= 5; i++) x.f[i] = m_f[i];
        x.cnt = m_cnt;
        x.err = m_err;
        x.q1  = (m_cnt >= 8) && (m_typ == 2'd1);
        x.q2  = (m_cnt >= 8) && (m_typ == 2'd2);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, '0);
        drive(1, 0, 1, mk_ts(8'h4A, 8'h00, 8'h02, 8'h01));
        e = sb.pop_front();
        e = sb.pop_front();
        checks++;
        if (pack_obs() !== pack_exp(e)) begin
            errors++;
            $display("FAIL reset_sb: got %h exp %h", pack_obs(), pack_exp(e));
        end
        checks++;
        if (pack_obs() !== 58'd0) begin
            errors++;
            $display("FAIL reset_zero: got %h exp 0", pack_obs());
        end
        drive(0, 0, 0, '0);
        e = sb.pop_front();
    endtask

    task automatic test_back_to_back();
        int upds = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, mk_ts(8'h4A, 8'h00, 8'h02, 8'h01));
            e = sb.pop_front();
            checks++;
            if (pack_obs() !== pack_exp(e)) begin
                errors++;
                $display("FAIL b2b_sb beat %0d: got %h exp %h", i, pack_obs(), pack_exp(e));
            end
            checks++;
            if (consec_cnt !== 4'(i + 1)) begin
                errors++;
                $display("FAIL b2b_cnt beat %0d: got %0d exp %0d", i, consec_cnt, i + 1);
            end
            if (ts_upd === 1'b1) upds++;
        end
        checks++;
        if (ts1_qual !== 1'b1 || ts_type !== 2'd1 || upds != 8) begin
            errors++;
            $display("FAIL b2b_qual: q1=%b type=%0d upds=%0d exp 1/1/8", ts1_qual, ts_type, upds);
        end
    endtask

    task automatic test_mismatch();
        drive(0, 1, 0, '0);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, mk_ts(8'h4A, (i == 4) ? 8'h05 : 8'h00, 8'h02, 8'h01));
            e = sb.pop_front();
            checks++;
            if (pack_obs() !== pack_exp(e)) begin
                errors++;
                $display("FAIL mismatch_sb beat %0d: got %h exp %h", i, pack_obs(), pack_exp(e));
            end
        end
        checks++;
        if (consec_cnt !== 4'd1 || ts_link !== 8'h05 || ts1_qual !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_load: cnt=%0d link=%h q1=%b exp 1/05/0", consec_cnt, ts_link, ts1_qual);
        end
    endtask

    task automatic test_type_change();
        drive(0, 1, 0, '0);
        e = sb.pop_front();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, mk_ts((i < 8) ? 8'h4A : 8'h45, 8'h00, 8'h02, 8'h01));
            e = sb.pop_front();
            checks++;
            if (pack_obs() !== pack_exp(e)) begin
                errors++;
                $display("FAIL type_sb beat %0d: got %h exp %h", i, pack_obs(), pack_exp(e));
            end
            if (i == 8) begin
                checks++;
                if (ts1_qual !== 1'b0 || ts2_qual !== 1'b0 || consec_cnt !== 4'd1 || ts_type !== 2'd2) begin
                    errors++;
                    $display("FAIL type_switch: q1=%b q2=%b cnt=%0d type=%0d exp 0/0/1/2",
                             ts1_qual, ts2_qual, consec_cnt, ts_type);
                end
            end
        end
        checks++;
        if (ts2_qual !== 1'b1) begin
            errors++;
            $display("FAIL type_ts2_qual: got %b exp 1", ts2_qual);
        end
    endtask

    task automatic test_malformed();
        logic [127:0] bad;
        logic [7:0]   err0;
        drive(0, 1, 0, '0);
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, mk_ts(8'h4A, 8'h03, 8'h02, 8'h01));
            e = sb.pop_front();
        end
        err0 = e.err;
        for (int i = 0; i < 2; i++) begin
            bad = mk_ts(8'h4A, 8'h03, 8'h02, 8'h01);
            if (i == 0) bad[7:0] = 8'h00;
            else        bad[79:72] = 8'h45;
            drive(0, 0, 1, bad);
            e = sb.pop_front();
            checks++;
            if (pack_obs() !== pack_exp(e)) begin
                errors++;
                $display("FAIL malformed_sb beat %0d: got %h exp %h", i, pack_obs(), pack_exp(e));
            end
        end
        checks++;
        if (err_cnt !== err0 + 8'd2 || consec_cnt !== 4'd0 || ts1_qual !== 1'b0 ||
            ts_link !== 8'h03 || ts_upd !== 1'b0) begin
            errors++;
            $display("FAIL malformed_state: err=%0d cnt=%0d q1=%b link=%h upd=%b exp %0d/0/0/03/0",
                     err_cnt, consec_cnt, ts1_qual, ts_link, ts_upd, err0 + 8'd2);
        end
    endtask

    task automatic test_gap();
        int pulses = 0;
        int at = -1;
        drive(0, 1, 0, '0);
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, mk_ts(8'h4A, 8'h00, 8'h02, 8'h01));
            e = sb.pop_front();
        end
        for (int i = 1; i <= 1100; i++) begin
            drive(0, 0, 0, '0);
            e = sb.pop_front();
            checks++;
            if (pack_obs() !== pack_exp(e)) begin
                errors++;
                $display("FAIL gap_sb idle %0d: got %h exp %h", i, pack_obs(), pack_exp(e));
            end
            if (gap_timeout === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        checks++;
        if (pulses != 1 || at != 1024 || consec_cnt !== 4'd0 || ts1_qual !== 1'b0 || ts_type !== 2'd1) begin
            errors++;
            $display("FAIL gap_expiry: pulses=%0d at=%0d cnt=%0d q1=%b type=%0d exp 1/1024/0/0/1",
                     pulses, at, consec_cnt, ts1_qual, ts_type);
        end
        drive(0, 0, 1, mk_ts(8'h4A, 8'h00, 8'h02, 8'h01));
        e = sb.pop_front();
        checks++;
        if (consec_cnt !== 4'd1 || pack_obs() !== pack_exp(e)) begin
            errors++;
            $display("FAIL gap_restart: cnt=%0d exp 1 (got %h exp %h)", consec_cnt, pack_obs(), pack_exp(e));
        end
    endtask

    task automatic test_clear_with_beat();
        logic [7:0]   err0;
        logic [127:0] bad;
        drive(0, 1, 0, '0);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, mk_ts(8'h4A, 8'h00, 8'h02, 8'h01));
            e = sb.pop_front();
        end
        err0 = err_cnt;
        drive(0, 1, 1, mk_ts(8'h4A, 8'h00, 8'h02, 8'h01));
        e = sb.pop_front();
        checks++;
        if (consec_cnt !== 4'd0 || ts_type !== 2'd0 || ts_upd !== 1'b0 || err_cnt !== err0 ||
            pack_obs() !== pack_exp(e)) begin
            errors++;
            $display("FAIL clear_beat: cnt=%0d type=%0d upd=%b err=%0d exp 0/0/0/%0d",
                     consec_cnt, ts_type, ts_upd, err_cnt, err0);
        end
        bad = '0;
        drive(0, 1, 1, bad);
        e = sb.pop_front();
        checks++;
        if (err_cnt !== err0) begin
            errors++;
            $display("FAIL clear_bad_beat: err=%0d exp %0d", err_cnt, err0);
        end
    endtask

    task automatic test_saturation();
        logic [127:0] bad;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, mk_ts(8'h45, 8'h01, 8'h00, 8'h02));
            e = sb.pop_front();
        end
        checks++;
        if (consec_cnt !== 4'd15 || ts2_qual !== 1'b1 || pack_obs() !== pack_exp(e)) begin
            errors++;
            $display("FAIL cnt_sat: cnt=%0d q2=%b exp 15/1", consec_cnt, ts2_qual);
        end
        bad = mk_ts(8'h4A, 8'h00, 8'h00, 8'h00);
        bad[127:120] = 8'h00;
        for (int i = 0; i < 260; i++) begin
            drive(0, 0, 1, bad);
            e = sb.pop_front();
        end
        checks++;
        if (err_cnt !== 8'd255 || pack_obs() !== pack_exp(e)) begin
            errors++;
            $display("FAIL err_sat: err=%0d exp 255", err_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, mk_ts(8'h4A, 8'h07, 8'h01, 8'h01));
            e = sb.pop_front();
        end
        drive(1, 0, 1, mk_ts(8'h4A, 8'h07, 8'h01, 8'h01));
        e = sb.pop_front();
        checks++;
        if (pack_obs() !== 58'd0 || pack_obs() !== pack_exp(e)) begin
            errors++;
            $display("FAIL reset_mid: got %h exp 0", pack_obs());
        end
        drive(0, 0, 1, mk_ts(8'h4A, 8'h07, 8'h01, 8'h01));
        e = sb.pop_front();
        checks++;
        if (consec_cnt !== 4'd1 || ts_link !== 8'h07 || ts_upd !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart: cnt=%0d link=%h upd=%b exp 1/07/1", consec_cnt, ts_link, ts_upd);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        rx_if.ts_i_vld = 1'b0;
        rx_if.ts_i = '0;
        m_typ = 0; m_cnt = 0; m_err = 0; m_gap = 0;
        for (int i = 1; i <= 5; i++) m_f[i] = 0;

        test_reset();
        test_back_to_back();
        test_mismatch();
        test_type_change();
        test_malformed();
        test_gap();
        test_clear_with_beat();
        test_saturation();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
